// File: rtl/fq_pkg.sv
// Shared types and helpers for the four-lane instruction fetch queue.
package fq_pkg;

    localparam int unsigned FQ_LANES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    // Number of leading contiguous valid lanes starting at lane 0 (0..4).
    function automatic logic [2:0] fq_prefix_cnt(input logic [3:0] valid);
        logic [2:0] n;
        n = 3'd0;
        if (valid[0]) begin
            n = 3'd1;
            if (valid[1]) begin
                n = 3'd2;
                if (valid[2]) begin
                    n = 3'd3;
                    if (valid[3]) begin
                        n = 3'd4;
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Circular entry storage: four writes and four combinational reads, each at consecutive addresses.
module fetch_queue_ram
    import fq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [FQ_LANES-1:0] we,
    input  logic [PTR_W-1:0]    waddr,
    input  fq_entry_t           wdata [FQ_LANES],
    input  logic [PTR_W-1:0]    raddr,
    output fq_entry_t           rdata [FQ_LANES]
);

    fq_entry_t        mem      [DEPTH];
    logic [PTR_W-1:0] wr_addr  [FQ_LANES];
    logic [PTR_W-1:0] rd_addr  [FQ_LANES];

    // Lane addresses wrap naturally modulo DEPTH through the pointer width.
    always_comb begin
        for (int i = 0; i < int'(FQ_LANES); i++) begin
            wr_addr[i] = waddr + PTR_W'(i);
            rd_addr[i] = raddr + PTR_W'(i);
        end
    end

    // Write the enabled lanes; addresses are distinct so lanes never collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(FQ_LANES); i++) begin
            if (we[i]) begin
                mem[wr_addr[i]] <= wdata[i];
            end
        end
    end

    // Combinational read of the four entries starting at raddr.
    always_comb begin
        for (int i = 0; i < int'(FQ_LANES); i++) begin
            rdata[i] = mem[rd_addr[i]];
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Four-lane fetch queue between instruction memory and decode, with single-cycle flush.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr0,
    input  logic [31:0]      in_instr1,
    input  logic [31:0]      in_instr2,
    input  logic [31:0]      in_instr3,
    input  logic [3:0]       in_valid,
    output logic             fetch_ready,
    output logic [31:0]      out_instr0,
    output logic [31:0]      out_instr1,
    output logic [31:0]      out_instr2,
    output logic [31:0]      out_instr3,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_pc2,
    output logic [31:0]      out_pc3,
    output logic [3:0]       out_valid,
    input  logic [2:0]       dq_cnt,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2:0]          enq_n;
    logic [2:0]          deq_n;
    logic [2:0]          dq_lim;
    logic [FQ_LANES-1:0] wr_en;
    logic [31:0]         in_instr [FQ_LANES];
    logic [31:0]         lane_pc [FQ_LANES];
    logic [31:0]         lane_instr [FQ_LANES];
    fq_entry_t           wr_data [FQ_LANES];
    fq_entry_t           rd_data [FQ_LANES];

    assign in_instr[0] = in_instr0;
    assign in_instr[1] = in_instr1;
    assign in_instr[2] = in_instr2;
    assign in_instr[3] = in_instr3;

    // Space for a full group is judged on the registered count only.
    assign fetch_ready = (count_q <= CNT_W'(DEPTH - FQ_LANES));
    assign count       = count_q;

    // Enqueue: accept only the leading valid lanes, nothing while full, flushing or in reset.
    always_comb begin
        enq_n = 3'd0;
        if (fetch_ready && !flush && rst_n) begin
            enq_n = fq_prefix_cnt(in_valid);
        end
        for (int i = 0; i < int'(FQ_LANES); i++) begin
            wr_en[i]         = (3'(i) < enq_n);
            wr_data[i].pc    = in_pc + 32'(4 * i);
            wr_data[i].instr = in_instr[i];
        end
    end

    // Dequeue: clamp decode's request to the lane count and to the occupancy.
    always_comb begin
        dq_lim = (dq_cnt > 3'(FQ_LANES)) ? 3'(FQ_LANES) : dq_cnt;
        deq_n  = dq_lim;
        if (CNT_W'(dq_lim) > count_q) begin
            deq_n = 3'(count_q);
        end
    end

    // Next pointer and occupancy; flush empties the queue and drops same-cycle traffic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_n);
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail_q),
        .wdata (wr_data),
        .raddr (head_q),
        .rdata (rd_data)
    );

    // Output lanes: valid prefix of min(count,4); invalid lanes read as zero.
    always_comb begin
        for (int i = 0; i < int'(FQ_LANES); i++) begin
            out_valid[i]  = (CNT_W'(i) < count_q);
            lane_pc[i]    = out_valid[i] ? rd_data[i].pc    : 32'h0;
            lane_instr[i] = out_valid[i] ? rd_data[i].instr : 32'h0;
        end
    end

    assign out_pc0    = lane_pc[0];
    assign out_pc1    = lane_pc[1];
    assign out_pc2    = lane_pc[2];
    assign out_pc3    = lane_pc[3];
    assign out_instr0 = lane_instr[0];
    assign out_instr1 = lane_instr[1];
    assign out_instr2 = lane_instr[2];
    assign out_instr3 = lane_instr[3];

endmodule
